// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core memory request, aligns store data and
// strobes to a 32-bit word bus, runs a valid/ready request handshake, waits
// for read data and returns the sign- or zero-extended load result.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_valid_i / req_ready_o        core request handshake (ready only in IDLE)
//   mem_wr_en_i, byte_en_i,
//   funct3_i, addr_i, wr_data_i      request fields, sampled on acceptance
//   bus_valid_o / bus_ready_i        bus request handshake
//   bus_we_o, bus_addr_o,
//   bus_wstrb_o, bus_wdata_o         bus request payload (word aligned)
//   bus_rvalid_i, bus_rdata_i        bus read response
//   done_o, err_o, rd_data_o         completion pulse, error flag, load result
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  mem_wr_en_i,
    input  logic [3:0]            byte_en_i,
    input  logic [2:0]            funct3_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wr_data_i,
    output logic                  bus_valid_o,
    input  logic                  bus_ready_i,
    output logic                  bus_we_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [3:0]            bus_wstrb_o,
    output logic [31:0]           bus_wdata_o,
    input  logic                  bus_rvalid_i,
    input  logic [31:0]           bus_rdata_i,
    output logic                  done_o,
    output logic                  err_o,
    output logic [31:0]           rd_data_o
);

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned LANE_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                  accept_c;
    logic                  req_err_c;
    logic                  capture_c;
    logic [3:0]            wstrb_c;
    logic [DATA_WIDTH-1:0] wdata_c;
    logic [LANE_WIDTH-1:0] lane_c;
    logic [DATA_WIDTH-1:0] load_c;

    logic [1:0]            off_q;
    logic [2:0]            funct3_q;

    // Request legality: size encoding plus natural alignment
    always_comb begin
        req_err_c = 1'b0;
        unique case (byte_en_i)
            4'b0001: req_err_c = 1'b0;
            4'b0011: req_err_c = addr_i[0];
            4'b1111: req_err_c = (addr_i[1:0] != 2'b00);
            default: req_err_c = 1'b1;
        endcase
    end

    // Store alignment: strobes shifted to the byte offset, data replicated per lane
    always_comb begin
        wstrb_c = mem_wr_en_i ? 4'(byte_en_i << addr_i[1:0]) : 4'b0000;
        unique case (byte_en_i)
            4'b0001: wdata_c = {4{wr_data_i[7:0]}};
            4'b0011: wdata_c = {2{wr_data_i[15:0]}};
            default: wdata_c = wr_data_i;
        endcase
    end

    // Load extraction: only the low half-word of the shifted lane is ever needed
    always_comb begin
        lane_c = LANE_WIDTH'(bus_rdata_i >> {off_q, 3'b000});
        unique case (funct3_q)
            3'b000:  load_c = {{24{lane_c[7]}}, lane_c[7:0]};
            3'b001:  load_c = {{16{lane_c[15]}}, lane_c[15:0]};
            3'b010:  load_c = bus_rdata_i;
            3'b100:  load_c = {24'h000000, lane_c[7:0]};
            3'b101:  load_c = {16'h0000, lane_c[15:0]};
            default: load_c = {24'h000000, lane_c[7:0]};
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        accept_c  = 1'b0;
        capture_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    accept_c = 1'b1;
                    state_d  = req_err_c ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (bus_ready_i) begin
                    state_d = bus_we_o ? DONE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (bus_rvalid_i) begin
                    capture_c = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, request registers and registered outputs (decoded from next state)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_o <= 1'b1;
            bus_valid_o <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wstrb_o <= 4'b0000;
            bus_wdata_o <= '0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            rd_data_o   <= '0;
            off_q       <= 2'b00;
            funct3_q    <= 3'b000;
        end else begin
            state_q     <= state_d;
            req_ready_o <= (state_d == IDLE);
            bus_valid_o <= (state_d == ISSUE);
            done_o      <= (state_d == DONE);
            // Error can only be flagged when entering DONE straight from IDLE
            err_o       <= accept_c && req_err_c;
            if (accept_c && !req_err_c) begin
                bus_we_o    <= mem_wr_en_i;
                bus_addr_o  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                bus_wstrb_o <= wstrb_c;
                bus_wdata_o <= wdata_c;
                off_q       <= addr_i[1:0];
                funct3_q    <= funct3_i;
            end
            if (capture_c) begin
                rd_data_o <= load_c;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        mem_wr_en_i;
    logic [3:0]  byte_en_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wr_data_i;
    logic        bus_valid_o;
    logic        bus_ready_i;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_wstrb_o;
    logic [31:0] bus_wdata_o;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        done_o;
    logic        err_o;
    logic [31:0] rd_data_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_rd;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .mem_wr_en_i (mem_wr_en_i),
        .byte_en_i   (byte_en_i),
        .funct3_i    (funct3_i),
        .addr_i      (addr_i),
        .wr_data_i   (wr_data_i),
        .bus_valid_o (bus_valid_o),
        .bus_ready_i (bus_ready_i),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_wstrb_o (bus_wstrb_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i (bus_rdata_i),
        .done_o      (done_o),
        .err_o       (err_o),
        .rd_data_o   (rd_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid_i = 1'b0; mem_wr_en_i = 1'b0; byte_en_i = 4'b0000; funct3_i = 3'b000;
        addr_i = 32'h0; wr_data_i = 32'h0; bus_ready_i = 1'b0; bus_rvalid_i = 1'b0;
        bus_rdata_i = 32'h0;
        tick();
        tick();
        n_checks++;
        if ({bus_valid_o, bus_we_o, done_o, err_o} !== 4'b0000) begin
            $display("FAIL reset_ctrl got=%b exp=0000", {bus_valid_o, bus_we_o, done_o, err_o});
            n_fail++;
        end
        n_checks++;
        if ({bus_addr_o, bus_wstrb_o, bus_wdata_o, rd_data_o} !== 100'h0) begin
            $display("FAIL reset_data addr=%h wstrb=%b wdata=%h rd=%h exp all zero",
                     bus_addr_o, bus_wstrb_o, bus_wdata_o, rd_data_o);
            n_fail++;
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (req_ready_o !== 1'b1 || done_o !== 1'b0) begin
            $display("FAIL reset_idle req_ready=%b done=%b exp 1 0", req_ready_o, done_o);
            n_fail++;
        end
        exp_rd = 32'h0;
    endtask

    task automatic test_byte_store();
        req_valid_i = 1'b1; mem_wr_en_i = 1'b1; byte_en_i = 4'b0001; funct3_i = 3'b000;
        addr_i = 32'h0000_1003; wr_data_i = 32'hDEAD_BEEF; bus_ready_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        n_checks++;
        if ({bus_valid_o, bus_we_o, req_ready_o, done_o} !== 4'b1100) begin
            $display("FAIL sb_c1_ctrl valid/we/ready/done=%b exp 1100",
                     {bus_valid_o, bus_we_o, req_ready_o, done_o});
            n_fail++;
        end
        n_checks++;
        if (bus_addr_o !== 32'h0000_1000 || bus_wstrb_o !== 4'b1000 || bus_wdata_o !== 32'hEFEF_EFEF) begin
            $display("FAIL sb_c1_payload addr=%h wstrb=%b wdata=%h exp 00001000 1000 efefefef",
                     bus_addr_o, bus_wstrb_o, bus_wdata_o);
            n_fail++;
        end
        tick();
        n_checks++;
        if ({done_o, err_o, bus_valid_o, req_ready_o} !== 4'b1000) begin
            $display("FAIL sb_c2 done/err/valid/ready=%b exp 1000", {done_o, err_o, bus_valid_o, req_ready_o});
            n_fail++;
        end
        tick();
        n_checks++;
        if ({done_o, req_ready_o} !== 2'b01) begin
            $display("FAIL sb_c3 done/ready=%b exp 01", {done_o, req_ready_o});
            n_fail++;
        end
    endtask

    task automatic test_extension();
        logic [2:0]  f3 [7];
        logic [3:0]  be [7];
        logic [31:0] ad [7];
        logic [31:0] rdv [7];
        logic [31:0] ex [7];
        f3[0] = 3'b000; be[0] = 4'b0001; ad[0] = 32'h2002; rdv[0] = 32'h12F45678; ex[0] = 32'hFFFF_FFF4;
        f3[1] = 3'b100; be[1] = 4'b0001; ad[1] = 32'h2002; rdv[1] = 32'h12F45678; ex[1] = 32'h0000_00F4;
        f3[2] = 3'b001; be[2] = 4'b0011; ad[2] = 32'h2002; rdv[2] = 32'h12F45678; ex[2] = 32'h0000_12F4;
        f3[3] = 3'b101; be[3] = 4'b0011; ad[3] = 32'h2002; rdv[3] = 32'h12F45678; ex[3] = 32'h0000_12F4;
        f3[4] = 3'b001; be[4] = 4'b0011; ad[4] = 32'h2000; rdv[4] = 32'h12F48678; ex[4] = 32'hFFFF_8678;
        f3[5] = 3'b010; be[5] = 4'b1111; ad[5] = 32'h2000; rdv[5] = 32'h12F45678; ex[5] = 32'h12F4_5678;
        f3[6] = 3'b000; be[6] = 4'b0001; ad[6] = 32'h2001; rdv[6] = 32'h12F45678; ex[6] = 32'h0000_0056;
        bus_ready_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            req_valid_i = 1'b1; mem_wr_en_i = 1'b0; byte_en_i = be[i]; funct3_i = f3[i];
            addr_i = ad[i]; wr_data_i = 32'h5555_5555;
            tick();
            req_valid_i = 1'b0;
            n_checks++;
            if (bus_valid_o !== 1'b1 || bus_we_o !== 1'b0 || bus_wstrb_o !== 4'b0000 ||
                bus_addr_o !== 32'h0000_2000) begin
                $display("FAIL ld%0d_issue valid=%b we=%b wstrb=%b addr=%h exp 1 0 0000 00002000",
                         i, bus_valid_o, bus_we_o, bus_wstrb_o, bus_addr_o);
                n_fail++;
            end
            tick();
            bus_rvalid_i = 1'b1; bus_rdata_i = rdv[i];
            tick();
            bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
            n_checks++;
            if (done_o !== 1'b1 || err_o !== 1'b0 || rd_data_o !== ex[i]) begin
                $display("FAIL ld%0d_result done=%b err=%b rd=%h exp 1 0 %h", i, done_o, err_o, rd_data_o, ex[i]);
                n_fail++;
            end
            exp_rd = ex[i];
            tick();
        end
    endtask

    task automatic test_backpressure();
        req_valid_i = 1'b1; mem_wr_en_i = 1'b1; byte_en_i = 4'b1111; funct3_i = 3'b010;
        addr_i = 32'h40; wr_data_i = 32'h1122_3344; bus_ready_i = 1'b0;
        tick();
        req_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus_valid_o !== 1'b1 || bus_addr_o !== 32'h40 || bus_wstrb_o !== 4'b1111 ||
                bus_wdata_o !== 32'h1122_3344 || req_ready_o !== 1'b0 || done_o !== 1'b0) begin
                $display("FAIL bp_c%0d valid=%b addr=%h wstrb=%b wdata=%h ready=%b done=%b exp 1 40 1111 11223344 0 0",
                         i + 1, bus_valid_o, bus_addr_o, bus_wstrb_o, bus_wdata_o, req_ready_o, done_o);
                n_fail++;
            end
            if (i == 3) bus_ready_i = 1'b1;
            tick();
        end
        n_checks++;
        if ({done_o, bus_valid_o, req_ready_o} !== 3'b100) begin
            $display("FAIL bp_done done/valid/ready=%b exp 100", {done_o, bus_valid_o, req_ready_o});
            n_fail++;
        end
        tick();
    endtask

    task automatic test_errors();
        logic        we [3];
        logic [3:0]  be [3];
        logic [2:0]  f3 [3];
        logic [31:0] ad [3];
        we[0] = 1'b0; be[0] = 4'b1111; f3[0] = 3'b010; ad[0] = 32'h102;
        we[1] = 1'b1; be[1] = 4'b0011; f3[1] = 3'b001; ad[1] = 32'h101;
        we[2] = 1'b0; be[2] = 4'b0101; f3[2] = 3'b010; ad[2] = 32'h0;
        bus_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid_i = 1'b1; mem_wr_en_i = we[i]; byte_en_i = be[i]; funct3_i = f3[i];
            addr_i = ad[i]; wr_data_i = 32'hFFFF_FFFF;
            tick();
            req_valid_i = 1'b0;
            n_checks++;
            if ({done_o, err_o, bus_valid_o} !== 3'b110 || rd_data_o !== exp_rd) begin
                $display("FAIL err%0d_c1 done/err/valid=%b rd=%h exp 110 %h",
                         i, {done_o, err_o, bus_valid_o}, rd_data_o, exp_rd);
                n_fail++;
            end
            tick();
            n_checks++;
            if ({done_o, err_o, bus_valid_o, req_ready_o} !== 4'b0001) begin
                $display("FAIL err%0d_c2 done/err/valid/ready=%b exp 0001",
                         i, {done_o, err_o, bus_valid_o, req_ready_o});
                n_fail++;
            end
        end
    endtask

    task automatic test_reset_mid_load();
        req_valid_i = 1'b1; mem_wr_en_i = 1'b0; byte_en_i = 4'b1111; funct3_i = 3'b010;
        addr_i = 32'h8; bus_ready_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({bus_valid_o, done_o} !== 2'b00 || rd_data_o !== 32'h0) begin
            $display("FAIL rst_mid valid/done=%b rd=%h exp 00 0", {bus_valid_o, done_o}, rd_data_o);
            n_fail++;
        end
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'hCAFE_BABE;
        tick();
        bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
        n_checks++;
        if ({done_o, req_ready_o, bus_valid_o} !== 3'b010 || rd_data_o !== 32'h0) begin
            $display("FAIL rst_late_rvalid done/ready/valid=%b rd=%h exp 010 0",
                     {done_o, req_ready_o, bus_valid_o}, rd_data_o);
            n_fail++;
        end
        tick();
        n_checks++;
        if (done_o !== 1'b0 || rd_data_o !== 32'h0) begin
            $display("FAIL rst_after done=%b rd=%h exp 0 0", done_o, rd_data_o);
            n_fail++;
        end
        exp_rd = 32'h0;
    endtask

    task automatic test_back_to_back();
        int          n_beats = 0;
        int          n_acc = 0;
        int          n_done = 0;
        int          acc_cyc [2];
        int          done_cyc [2];
        logic        beat_we [2];
        logic [31:0] beat_addr [2];
        logic [31:0] beat_wdata [2];
        logic        switch_req;
        logic        drop_req;
        acc_cyc[0] = -1; acc_cyc[1] = -1; done_cyc[0] = -1; done_cyc[1] = -1;
        bus_ready_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0BAD_F00D;
        req_valid_i = 1'b1; mem_wr_en_i = 1'b0; byte_en_i = 4'b1111; funct3_i = 3'b010;
        addr_i = 32'h0; wr_data_i = 32'h0;
        for (int c = 0; c < 20; c++) begin
            switch_req = 1'b0;
            drop_req = 1'b0;
            if (bus_valid_o && bus_ready_i) begin
                if (n_beats < 2) begin
                    beat_we[n_beats] = bus_we_o;
                    beat_addr[n_beats] = bus_addr_o;
                    beat_wdata[n_beats] = bus_wdata_o;
                end
                n_beats++;
            end
            if (done_o) begin
                if (n_done < 2) done_cyc[n_done] = c;
                n_done++;
            end
            if (req_ready_o && req_valid_i) begin
                if (n_acc < 2) acc_cyc[n_acc] = c;
                n_acc++;
                if (n_acc == 1) switch_req = 1'b1;
                if (n_acc == 2) drop_req = 1'b1;
            end
            tick();
            if (switch_req) begin
                mem_wr_en_i = 1'b1; addr_i = 32'h4; wr_data_i = 32'hA5A5_A5A5;
            end
            if (drop_req) req_valid_i = 1'b0;
        end
        bus_rvalid_i = 1'b0;
        n_checks++;
        if (n_acc !== 2 || acc_cyc[0] !== 0 || acc_cyc[1] !== 4) begin
            $display("FAIL b2b_accept count=%0d cycles=%0d,%0d exp 2 0,4", n_acc, acc_cyc[0], acc_cyc[1]);
            n_fail++;
        end
        n_checks++;
        if (n_done !== 2 || done_cyc[0] !== 3 || done_cyc[1] !== 6) begin
            $display("FAIL b2b_done count=%0d cycles=%0d,%0d exp 2 3,6", n_done, done_cyc[0], done_cyc[1]);
            n_fail++;
        end
        n_checks++;
        if (n_beats !== 2) begin
            $display("FAIL b2b_beats count=%0d exp 2", n_beats);
            n_fail++;
        end else begin
            n_checks++;
            if (beat_we[0] !== 1'b0 || beat_addr[0] !== 32'h0 || beat_we[1] !== 1'b1 ||
                beat_addr[1] !== 32'h4 || beat_wdata[1] !== 32'hA5A5_A5A5) begin
                $display("FAIL b2b_order we0=%b a0=%h we1=%b a1=%h wd1=%h exp 0 0 1 4 a5a5a5a5",
                         beat_we[0], beat_addr[0], beat_we[1], beat_addr[1], beat_wdata[1]);
                n_fail++;
            end
        end
        n_checks++;
        if (rd_data_o !== 32'h0BAD_F00D || req_ready_o !== 1'b1) begin
            $display("FAIL b2b_final rd=%h ready=%b exp 0badf00d 1", rd_data_o, req_ready_o);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_byte_store();
        test_extension();
        test_backpressure();
        test_errors();
        test_reset_mid_load();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
